// File: rtl/turbo_rsc_encoder.sv
// -----------------------------------------------------------------------------
// turbo_rsc_encoder
//
// LTE turbo encoder core built from one or two 8-state recursive systematic
// convolutional (RSC) encoders. The block length is programmed per block, input
// bits arrive under a per-bit valid, and each constituent encoder is driven back
// to the all-zero state by three tail cycles once its data has been consumed.
//
// Each RSC encoder uses feedback polynomial g0 = 1 + D^2 + D^3 and forward
// polynomial g1 = 1 + D + D^3. The encoder state is {q2, q1, q0}.
//
// Ports
//   clk        : single clock; all state changes on the rising edge
//   aclr       : asynchronous active-high reset
//   start      : one-cycle pulse; latches k_len and begins a block
//   k_len      : block length in bits, sampled only on an accepted start
//   in_valid   : ck/ck2 carry a data bit this cycle (used only in DATA)
//   ck         : natural-order data bit for encoder 1
//   ck2        : interleaved data bit for encoder 2 (unused when NUM_ENC=1)
//   xk         : systematic output (data bit or tail systematic bit)
//   zk         : encoder-1 parity output
//   zk2        : encoder-2 parity output (always 0 when NUM_ENC=1)
//   out_valid  : xk/zk/zk2 carry a valid output this cycle
//   out_tail   : the current output is a tail bit
//   out_last   : the current output is the final output of the block
//   busy       : a block is in progress (high through the out_last cycle)
//   st1, st2   : encoder register states {q2,q1,q0}, for debug
//
// Handshake: a data bit is consumed on every rising edge where the FSM is in
// DATA and in_valid is high; there is no back-pressure on the output side, and
// each consumed bit (or tail step) produces exactly one registered output with
// out_valid high on the following cycle.
// -----------------------------------------------------------------------------
module turbo_rsc_encoder #(
   parameter int NUM_ENC = 2,
   parameter int K_W     = 13
) (
   input  logic           clk,
   input  logic           aclr,
   input  logic           start,
   input  logic [K_W-1:0] k_len,
   input  logic           in_valid,
   input  logic           ck,
   input  logic           ck2,
   output logic           xk,
   output logic           zk,
   output logic           zk2,
   output logic           out_valid,
   output logic           out_tail,
   output logic           out_last,
   output logic           busy,
   output logic [2:0]     st1,
   output logic [2:0]     st2
);

   localparam logic TWO_ENC = (NUM_ENC == 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DATA  = 2'd1,
      S_TAIL1 = 2'd2,
      S_TAIL2 = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [K_W-1:0] klen_q, klen_d;
   logic [K_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [1:0]     tail_cnt_q, tail_cnt_d;
   logic [2:0]     st1_q, st1_d;
   logic [2:0]     st2_q, st2_d;
   logic           xk_q, xk_d;
   logic           zk_q, zk_d;
   logic           zk2_q, zk2_d;
   logic           out_valid_q, out_valid_d;
   logic           out_tail_q, out_tail_d;
   logic           out_last_q, out_last_d;

   logic           accept_start;
   logic           tail_phase;
   logic [4:0]     step1;
   logic [4:0]     step2;

   // One trellis step. Returns {next_state[2:0], systematic, parity}.
   // In a tail step the input is forced to q1^q2 so the feedback sum is 0,
   // which shifts a zero into q0 and flushes the register in three steps.
   function automatic logic [4:0] rsc_step(input logic [2:0] st,
                                           input logic       c,
                                           input logic       tail);
      logic sys;
      logic s;
      logic par;
      sys = tail ? (st[1] ^ st[2]) : c;
      s   = sys ^ st[1] ^ st[2];
      par = s ^ st[0] ^ st[2];
      return {st[1], st[0], s, sys, par};
   endfunction

   assign tail_phase = (state_q != S_DATA);
   assign step1      = rsc_step(st1_q, ck, tail_phase);
   assign step2      = rsc_step(st2_q, ck2 & TWO_ENC, tail_phase);

   // The FSM is already back in IDLE while the final tail output is on the
   // pins; a start in that cycle is still refused so busy covers out_last.
   assign accept_start = start && (k_len != '0) && (state_q == S_IDLE) && !out_last_q;

   always_comb begin
      state_d     = state_q;
      klen_d      = klen_q;
      bit_cnt_d   = bit_cnt_q;
      tail_cnt_d  = tail_cnt_q;
      st1_d       = st1_q;
      st2_d       = st2_q;
      xk_d        = 1'b0;
      zk_d        = 1'b0;
      zk2_d       = 1'b0;
      out_valid_d = 1'b0;
      out_tail_d  = 1'b0;
      out_last_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept_start) begin
               state_d    = S_DATA;
               klen_d     = k_len;
               bit_cnt_d  = '0;
               tail_cnt_d = 2'd0;
               st1_d      = 3'b000;
               st2_d      = 3'b000;
            end
         end

         S_DATA: begin
            if (in_valid) begin
               st1_d       = step1[4:2];
               xk_d        = ck;
               zk_d        = step1[0];
               out_valid_d = 1'b1;
               if (TWO_ENC) begin
                  st2_d = step2[4:2];
                  zk2_d = step2[0];
               end
               if (bit_cnt_q == klen_q - 1'b1) begin
                  state_d    = S_TAIL1;
                  bit_cnt_d  = '0;
                  tail_cnt_d = 2'd0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end

         S_TAIL1: begin
            st1_d       = step1[4:2];
            xk_d        = step1[1];
            zk_d        = step1[0];
            out_valid_d = 1'b1;
            out_tail_d  = 1'b1;
            if (tail_cnt_q == 2'd2) begin
               tail_cnt_d = 2'd0;
               if (TWO_ENC) begin
                  state_d = S_TAIL2;
               end else begin
                  state_d    = S_IDLE;
                  out_last_d = 1'b1;
               end
            end else begin
               tail_cnt_d = tail_cnt_q + 2'd1;
            end
         end

         S_TAIL2: begin
            st2_d       = step2[4:2];
            xk_d        = step2[1];
            zk2_d       = step2[0];
            out_valid_d = 1'b1;
            out_tail_d  = 1'b1;
            if (tail_cnt_q == 2'd2) begin
               tail_cnt_d = 2'd0;
               state_d    = S_IDLE;
               out_last_d = 1'b1;
            end else begin
               tail_cnt_d = tail_cnt_q + 2'd1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state_q     <= S_IDLE;
         klen_q      <= '0;
         bit_cnt_q   <= '0;
         tail_cnt_q  <= 2'd0;
         st1_q       <= 3'b000;
         st2_q       <= 3'b000;
         xk_q        <= 1'b0;
         zk_q        <= 1'b0;
         zk2_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_tail_q  <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         klen_q      <= klen_d;
         bit_cnt_q   <= bit_cnt_d;
         tail_cnt_q  <= tail_cnt_d;
         st1_q       <= st1_d;
         st2_q       <= st2_d;
         xk_q        <= xk_d;
         zk_q        <= zk_d;
         zk2_q       <= zk2_d;
         out_valid_q <= out_valid_d;
         out_tail_q  <= out_tail_d;
         out_last_q  <= out_last_d;
      end
   end

   assign xk        = xk_q;
   assign zk        = zk_q;
   assign zk2       = zk2_q;
   assign out_valid = out_valid_q;
   assign out_tail  = out_tail_q;
   assign out_last  = out_last_q;
   assign busy      = (state_q != S_IDLE) || out_last_q;
   assign st1       = st1_q;
   assign st2       = st2_q;

endmodule

// File: tb/tb_turbo_rsc_encoder.sv
// -----------------------------------------------------------------------------
// tb_turbo_rsc_encoder
//
// Bench for turbo_rsc_encoder (NUM_ENC=2). Expected output words are produced
// from the generator polynomials written as sequence recurrences over whole
// arrays: a[n] = c[n] ^ a[n-2] ^ a[n-3], parity[n] = a[n] ^ a[n-1] ^ a[n-3],
// with a[n] = 0 during termination. Words are {xk, zk, zk2, out_tail, out_last}.
// -----------------------------------------------------------------------------
module tb_turbo_rsc_encoder;

   localparam int K_W     = 13;
   localparam int NUM_ENC = 2;
   localparam int W       = 5;

   logic           clk;
   logic           aclr;
   logic           start;
   logic [K_W-1:0] k_len;
   logic           in_valid;
   logic           ck;
   logic           ck2;
   logic           xk;
   logic           zk;
   logic           zk2;
   logic           out_valid;
   logic           out_tail;
   logic           out_last;
   logic           busy;
   logic [2:0]     st1;
   logic [2:0]     st2;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];
   logic         ck_arr[0:8191];
   logic         ck2_arr[0:8191];
   int           a1[0:8199];
   int           a2[0:8199];
   bit           last_seen;

   turbo_rsc_encoder #(
      .NUM_ENC (NUM_ENC),
      .K_W     (K_W)
   ) dut (
      .clk       (clk),
      .aclr      (aclr),
      .start     (start),
      .k_len     (k_len),
      .in_valid  (in_valid),
      .ck        (ck),
      .ck2       (ck2),
      .xk        (xk),
      .zk        (zk),
      .zk2       (zk2),
      .out_valid (out_valid),
      .out_tail  (out_tail),
      .out_last  (out_last),
      .busy      (busy),
      .st1       (st1),
      .st2       (st2)
   );

   // clock / timeout
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   function automatic int h1(input int n);
      return (n < 0) ? 0 : a1[n];
   endfunction

   function automatic int h2(input int n);
      return (n < 0) ? 0 : a2[n];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Full expected output sequence for a k-bit block from ck_arr/ck2_arr.
   task automatic build_model(input int k);
      int x;
      int z;
      int z2;
      exp_q.delete();
      for (int n = 0; n < k; n++) begin
         a1[n] = int'(ck_arr[n]) ^ h1(n - 2) ^ h1(n - 3);
         z     = a1[n] ^ h1(n - 1) ^ h1(n - 3);
         a2[n] = int'(ck2_arr[n]) ^ h2(n - 2) ^ h2(n - 3);
         z2    = a2[n] ^ h2(n - 1) ^ h2(n - 3);
         exp_q.push_back({ck_arr[n], z[0], z2[0], 1'b0, 1'b0});
      end
      for (int n = k; n < k + 3; n++) begin
         a1[n] = 0;
         x     = h1(n - 2) ^ h1(n - 3);
         z     = h1(n - 1) ^ h1(n - 3);
         exp_q.push_back({x[0], z[0], 1'b0, 1'b1, 1'b0});
      end
      for (int n = k; n < k + 3; n++) begin
         a2[n] = 0;
         x     = h2(n - 2) ^ h2(n - 3);
         z2    = h2(n - 1) ^ h2(n - 3);
         exp_q.push_back({x[0], 1'b0, z2[0], 1'b1, (n == k + 2)});
      end
   endtask

   // One clock: drive, wait for the edge, sample 1 time unit later.
   task automatic cyc(input logic s, input logic [K_W-1:0] kl, input logic v,
                      input logic c, input logic c2, input bit data_phase);
      logic [W-1:0] word;
      start    = s;
      k_len    = kl;
      in_valid = v;
      ck       = c;
      ck2      = c2;
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = 1'b0;
      word     = {xk, zk, zk2, out_tail, out_last};
      if (data_phase) check_eq("data_out_valid", out_valid, v);
      if (out_valid === 1'b1) begin
         obs_q.push_back(word);
         checks++;
         assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL extra_output observed=%b expected=none", word);
         end
         if (exp_q.size() > 0) check_eq("out_word", word, exp_q.pop_front());
         if (out_last === 1'b1) last_seen = 1'b1;
      end
   endtask

   task automatic run_block(input int k, input int gap_pct, input int rogue_at, input int abort_at);
      int   i;
      int   guard;
      logic v;
      build_model(k);
      obs_q.delete();
      last_seen = 1'b0;
      cyc(1'b1, K_W'(k), 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("busy_after_start", busy, 1'b1);
      check_eq("st1_after_start", st1, 3'b000);
      check_eq("st2_after_start", st2, 3'b000);
      i     = 0;
      guard = 0;
      while (i < k && guard < 60000) begin
         guard++;
         if (i == abort_at) begin
            aclr = 1'b1;
            #1;
            check_eq("aclr_word", {xk, zk, zk2, out_tail, out_last}, 5'b0);
            check_eq("aclr_valid", out_valid, 1'b0);
            check_eq("aclr_busy", busy, 1'b0);
            check_eq("aclr_states", {st1, st2}, 6'b0);
            @(posedge clk);
            #1;
            check_eq("aclr_hold_valid", out_valid, 1'b0);
            aclr = 1'b0;
            exp_q.delete();
            return;
         end
         v = ($urandom_range(0, 99) >= gap_pct);
         cyc((i == rogue_at), K_W'(k + 7), v, ck_arr[i], ck2_arr[i], 1'b1);
         if (v) i++;
      end
      check_eq("data_budget", i, k);
      // Tail phase: in_valid/ck/ck2 are toggled randomly and must be ignored.
      guard = 0;
      while (!last_seen && guard < 20) begin
         guard++;
         cyc(1'b0, '0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0);
      end
      check_eq("last_seen", last_seen, 1'b1);
      check_eq("busy_on_last", busy, 1'b1);
      // A start presented during the out_last cycle must be refused.
      cyc(1'b1, K_W'(5), 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("busy_after_last", busy, 1'b0);
      check_eq("valid_after_last", out_valid, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("busy_still_idle", busy, 1'b0);
      check_eq("exp_q_drained", exp_q.size(), 0);
      check_eq("output_count", obs_q.size(), k + 3 * NUM_ENC);
      check_eq("st1_end", st1, 3'b000);
      check_eq("st2_end", st2, 3'b000);
   endtask

   task automatic fill_random(input int k);
      for (int n = 0; n < k; n++) begin
         ck_arr[n]  = 1'($urandom_range(0, 1));
         ck2_arr[n] = 1'($urandom_range(0, 1));
      end
   endtask

   initial begin
      logic [W-1:0] k1_exp[7];
      k1_exp = '{5'b11000, 5'b01010, 5'b10010, 5'b11010, 5'b00010, 5'b00010, 5'b00011};

      // reset
      aclr     = 1'b1;
      start    = 1'b0;
      k_len    = '0;
      in_valid = 1'b0;
      ck       = 1'b0;
      ck2      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_word", {xk, zk, zk2, out_tail, out_last}, 5'b0);
      check_eq("reset_valid", out_valid, 1'b0);
      check_eq("reset_busy", busy, 1'b0);
      check_eq("reset_states", {st1, st2}, 6'b0);
      aclr = 1'b0;
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      // start with k_len = 0 is ignored
      exp_q.delete();
      cyc(1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("k0_busy", busy, 1'b0);
      for (int n = 0; n < 4; n++) begin
         cyc(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
         check_eq("k0_no_valid", out_valid, 1'b0);
         check_eq("k0_busy_idle", busy, 1'b0);
      end

      // k_len = 1, ck = 1
      ck_arr[0]  = 1'b1;
      ck2_arr[0] = 1'b0;
      run_block(1, 0, -1, -1);
      for (int n = 0; n < 7; n++) begin
         if (n < obs_q.size()) check_eq("k1_word", obs_q[n], k1_exp[n]);
      end

      // k_len = 40, all zeros
      for (int n = 0; n < 40; n++) begin
         ck_arr[n]  = 1'b0;
         ck2_arr[n] = 1'b0;
      end
      run_block(40, 0, -1, -1);
      for (int n = 0; n < obs_q.size(); n++) begin
         check_eq("zero_bits", obs_q[n][4:2], 3'b000);
         check_eq("zero_tail_flag", obs_q[n][1], (n >= 40));
      end

      // full-size block with random data and random in_valid gaps
      fill_random(6144);
      run_block(6144, 25, -1, -1);

      // start pulsed mid-DATA with another length is ignored
      fill_random(300);
      run_block(300, 20, 50, -1);

      // aclr mid-DATA at bit 100, then a clean 40-bit block
      fill_random(200);
      run_block(200, 10, -1, 100);
      fill_random(40);
      run_block(40, 30, -1, -1);

      // a few short random blocks
      for (int b = 0; b < 4; b++) begin
         int k;
         k = $urandom_range(2, 64);
         fill_random(k);
         run_block(k, 40, -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
